// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types, width helpers and saturation for the perceptron MAC
package perceptron_pkg;

    localparam int SAT_W = 128;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} mac_state_t;

    function automatic int calc_w(input int sign, input int q_m, input int q_n);
        return sign + q_m + q_n;
    endfunction

    function automatic int calc_acc_w(input int w, input int q_n, input int n_inputs);
        return 2 * w - q_n + $clog2(n_inputs + 1);
    endfunction

    // Returns {overflow, value}; value is the clamp to a w-bit signed range, sign-extended to SAT_W.
    function automatic logic [SAT_W:0] sat_to_w(input logic signed [SAT_W-1:0] acc, input int w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
        lo = ~hi;
        if (acc > hi) begin
            sat_to_w = {1'b1, hi};
        end else if (acc < lo) begin
            sat_to_w = {1'b1, lo};
        end else begin
            sat_to_w = {1'b0, acc};
        end
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// rtl/fxp_mul.sv - combinational signed fixed-point multiply rescaled by Q_N fractional bits
module fxp_mul #(
    parameter int W   = 33,
    parameter int Q_N = 16
) (
    input  logic signed [W-1:0]       a_i,
    input  logic signed [W-1:0]       b_i,
    output logic signed [2*W-Q_N-1:0] p_o
);

    logic signed [2*W-1:0] full;

    assign full = a_i * b_i;
    // Arithmetic shift rounds toward -inf; the dropped top bits are pure sign copies.
    assign p_o  = (2*W-Q_N)'(full >>> Q_N);

endmodule

// File: rtl/perceptron_mac.sv
// rtl/perceptron_mac.sv - bias + sum(x*w) accumulator with saturated valid/ready result port
module perceptron_mac
    import perceptron_pkg::*;
#(
    parameter int SIGN     = 1,
    parameter int Q_M      = 16,
    parameter int Q_N      = 16,
    parameter int N_INPUTS = 4,
    localparam int W       = calc_w(SIGN, Q_M, Q_N)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic [W-1:0] bias_i,
    input  logic         x_valid_i,
    output logic         x_ready_o,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] w_i,
    output logic [W-1:0] summation_o,
    output logic         summation_valid_o,
    input  logic         summation_ready_i,
    output logic         overflow_o,
    output logic         busy_o
);

    localparam int ACC_W  = calc_acc_w(W, Q_N, N_INPUTS);
    localparam int PROD_W = 2 * W - Q_N;
    localparam int CNT_W  = $clog2(N_INPUTS + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_INPUTS - 1);

    mac_state_t              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [W-1:0]            sum_q, sum_d;
    logic                    ovf_q, ovf_d;
    logic signed [PROD_W-1:0] prod;
    logic [SAT_W:0]          sat;

    fxp_mul #(
        .W   (W),
        .Q_N (Q_N)
    ) u_mul (
        .a_i (x_i),
        .b_i (w_i),
        .p_o (prod)
    );

    assign acc_sum = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sat     = sat_to_w({{(SAT_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum}, W);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = {{(ACC_W-W){bias_i[W-1]}}, bias_i};
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_valid_i) begin
                    acc_d   = acc_sum;
                    count_d = count_q + 1'b1;
                    // Result registers load on the final beat so DONE presents a stable value.
                    if (count_q == LAST) begin
                        sum_d   = W'(sat[SAT_W-1:0]);
                        ovf_d   = sat[SAT_W];
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (summation_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            acc_q   <= '0;
            count_q <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign x_ready_o         = (state_q == ACCUM);
    assign summation_valid_o = (state_q == DONE);
    assign busy_o            = (state_q != IDLE);
    assign summation_o       = sum_q;
    assign overflow_o        = ovf_q;

endmodule

// File: tb/tb_perceptron_mac.sv
// tb/tb_perceptron_mac.sv - scoreboard bench for perceptron_mac at default Q16.16, four inputs
module tb_perceptron_mac;

    localparam logic [32:0] ONE  = 33'h0_0001_0000;
    localparam logic [32:0] HALF = 33'h0_0000_8000;
    localparam logic [32:0] JUNK = 33'h1_2345_6789;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i, x_valid_i, summation_ready_i;
    logic [32:0] bias_i, x_i, w_i;
    logic        x_ready_o, summation_valid_o, overflow_o, busy_o;
    logic [32:0] summation_o;

    logic [32:0] xs [4];
    logic [32:0] ws [4];
    logic [33:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    perceptron_mac dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start_i),
        .bias_i            (bias_i),
        .x_valid_i         (x_valid_i),
        .x_ready_o         (x_ready_o),
        .x_i               (x_i),
        .w_i               (w_i),
        .summation_o       (summation_o),
        .summation_valid_o (summation_valid_o),
        .summation_ready_i (summation_ready_i),
        .overflow_o        (overflow_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && summation_valid_o && summation_ready_i) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected", 1, 0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("sb_sum", summation_o, e[32:0]);
                check("sb_ovf", overflow_o, e[33]);
            end
        end
    end

    function automatic logic [33:0] model_sum(input logic [32:0] b);
        logic signed [127:0] acc, xe, we, p, hi, lo;
        acc = {{95{b[32]}}, b};
        for (int i = 0; i < 4; i++) begin
            xe  = {{95{xs[i][32]}}, xs[i]};
            we  = {{95{ws[i][32]}}, ws[i]};
            p   = (xe * we) >>> 16;
            acc = acc + p;
        end
        hi = 128'sd4294967295;
        lo = -128'sd4294967296;
        if (acc > hi) return {1'b1, 33'h0_FFFF_FFFF};
        if (acc < lo) return {1'b1, 33'h1_0000_0000};
        return {1'b0, acc[32:0]};
    endfunction

    task automatic set_all(input logic [32:0] x, input logic [32:0] w);
        for (int i = 0; i < 4; i++) begin
            xs[i] = x;
            ws[i] = w;
        end
    endtask

    task automatic run_sum(input logic [32:0] bias, input logic [6:0] vpat, input int hold,
                           input bit keep_start, input logic [32:0] exp_s, input logic exp_o);
        int b;
        int cyc;
        logic v;
        check("idle_busy", busy_o, 0);
        start_i = 1'b1;
        bias_i  = bias;
        exp_q.push_back({exp_o, exp_s});
        step();
        if (!keep_start) start_i = 1'b0;
        bias_i = JUNK;
        check("accum_ready", x_ready_o, 1);
        b   = 0;
        cyc = 0;
        while (b < 4 && cyc < 40) begin
            check("early_valid", summation_valid_o, 0);
            v         = (cyc < 7) ? vpat[cyc] : 1'b1;
            x_valid_i = v;
            x_i       = v ? xs[b] : JUNK;
            w_i       = v ? ws[b] : JUNK;
            step();
            if (v) b++;
            cyc++;
        end
        check("beats", b, 4);
        x_valid_i = 1'b0;
        check("latency_valid", summation_valid_o, 1);
        for (int h = 0; h < hold; h++) begin
            x_valid_i = 1'b1;
            x_i       = JUNK;
            w_i       = JUNK;
            check("hold_ready", x_ready_o, 0);
            check("hold_valid", summation_valid_o, 1);
            check("hold_sum", summation_o, exp_s);
            check("hold_ovf", overflow_o, exp_o);
            step();
        end
        x_valid_i = 1'b0;
        check("done_sum", summation_o, exp_s);
        check("done_ovf", overflow_o, exp_o);
        summation_ready_i = 1'b1;
        step();
        summation_ready_i = 1'b0;
        check("post_valid", summation_valid_o, 0);
        check("post_busy", busy_o, 0);
    endtask

    initial begin
        logic [63:0] r;
        logic [33:0] m;
        rst_n = 1'b0;
        start_i = 1'b0;
        x_valid_i = 1'b0;
        summation_ready_i = 1'b0;
        bias_i = '0;
        x_i = '0;
        w_i = '0;
        repeat (2) step();
        check("rst_valid", summation_valid_o, 0);
        check("rst_sum", summation_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", x_ready_o, 0);
        rst_n = 1'b1;
        step();

        set_all(ONE, HALF);
        run_sum(33'h0, 7'h7F, 0, 1'b0, 33'h0_0002_0000, 1'b0);
        set_all(33'h1_FFFF_0000, ONE);
        run_sum(HALF, 7'h7F, 0, 1'b0, 33'h1_FFFC_8000, 1'b0);
        set_all(33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF);
        run_sum(33'h0, 7'h7F, 0, 1'b0, 33'h0_FFFF_FFFF, 1'b1);
        set_all(33'h0_FFFF_FFFF, 33'h1_0000_0001);
        run_sum(33'h0, 7'h7F, 1, 1'b0, 33'h1_0000_0000, 1'b1);

        // Abort a partial sum with an asynchronous reset between clock edges.
        set_all(ONE, HALF);
        start_i = 1'b1;
        bias_i  = 33'h0;
        step();
        start_i   = 1'b0;
        x_valid_i = 1'b1;
        x_i = ONE;
        w_i = HALF;
        repeat (2) step();
        x_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy_o, 0);
        check("abort_valid", summation_valid_o, 0);
        check("abort_sum", summation_o, 0);
        check("abort_ovf", overflow_o, 0);
        check("abort_ready", x_ready_o, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        run_sum(33'h0, 7'h7F, 0, 1'b0, 33'h0_0002_0000, 1'b0);

        run_sum(33'h0, 7'b1011001, 5, 1'b0, 33'h0_0002_0000, 1'b0);

        run_sum(33'h0, 7'h7F, 0, 1'b1, 33'h0_0002_0000, 1'b0);
        run_sum(33'h0, 7'h7F, 0, 1'b0, 33'h0_0002_0000, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                r = {$urandom(), $urandom()};
                xs[i] = (t < 3) ? {{13{r[19]}}, r[19:0]} : r[32:0];
                r = {$urandom(), $urandom()};
                ws[i] = (t < 3) ? {{13{r[51]}}, r[51:32]} : r[32:0];
            end
            r = {$urandom(), $urandom()};
            m = model_sum(r[32:0]);
            run_sum(r[32:0], 7'($urandom_range(0, 127)), t, 1'b0, m[32:0], m[33]);
        end

        step();
        check("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
